// File: rtl/lcd_3wire_serial_ctrl.sv
// lcd_3wire_serial_ctrl: serialises one 16-bit command word per iSTR rising
// edge, MSB first, onto the panel's 3-wire port. It also generates the divided
// clock that the register-config sequencer runs on.
//   iCLK, iRST         system clock, asynchronous active-high reset
//   iDATA, iSTR        command word {addr[5:0], rw, rsvd, wdata[7:0]} and start strobe
//   oRDY, oACK         idle/result valid, transfer accepted
//   oRDATA             data returned by the last read frame
//   oCLK               sequencer clock, period 2*CLK_DIV iCLK cycles
//   I2S_EN/CLK/DATA    panel enable (low), serial clock (idles high), data (tri-state)
// Optional: `define LCD_3WIRE_READBACK_VERIFY_EN to follow every write frame
// with a readback of the same address; oACK then reports whether it matched.
module lcd_3wire_serial_ctrl #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [15:0] iDATA,
  input  logic        iSTR,
  output logic        oACK,
  output logic        oRDY,
  output logic        oCLK,
  output logic [7:0]  oRDATA,
  output logic        I2S_EN,
  output logic        I2S_CLK,
  inout  wire         I2S_DATA
);

  // ARM holds a latched command until the next tick so that SETUP is a full tick.
  typedef enum logic [2:0] {
    IDLE, ARM, SETUP, BIT_LO, BIT_HI, HOLD, GAP, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q;
  logic        clk_q;
  logic        tick;
  logic        str_q, str_prev_q;
  logic        start;
  logic [15:0] cmd_q;
  logic [3:0]  idx_q;
  logic [7:0]  rsh_q;
  logic        rdy_q, ack_q;
  logic [7:0]  rdata_q;
  logic        drv_en, drv_bit;
  logic        rdbk;

`ifdef LCD_3WIRE_READBACK_VERIFY_EN
  logic        vfy_q;
  // A finished write frame chains straight into its readback frame.
  assign rdbk = ~cmd_q[9];
`else
  assign rdbk = 1'b0;
`endif

  assign tick   = (div_q == 8'(CLK_DIV - 1));
  assign start  = str_q & ~str_prev_q;
  assign oCLK   = clk_q;
  assign oRDY   = rdy_q;
  assign oACK   = ack_q;
  assign oRDATA = rdata_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 8'd1;
      if (tick) clk_q <= ~clk_q;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     if (tick) state_d = SETUP;
      SETUP:   if (tick) state_d = BIT_LO;
      BIT_LO:  if (tick) state_d = BIT_HI;
      BIT_HI:  if (tick) state_d = (idx_q == '0) ? HOLD : BIT_LO;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick && idx_q == '0) state_d = rdbk ? SETUP : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    I2S_EN  = 1'b1;
    I2S_CLK = 1'b1;
    drv_en  = 1'b0;
    drv_bit = cmd_q[idx_q];
    unique case (state_q)
      SETUP:  I2S_EN = 1'b0;
      BIT_LO: begin
        I2S_EN  = 1'b0;
        I2S_CLK = 1'b0;
        // Read frames release the line from bit 7 down.
        drv_en  = ~cmd_q[9] | idx_q[3];
      end
      BIT_HI: begin
        I2S_EN = 1'b0;
        drv_en = ~cmd_q[9] | idx_q[3];
      end
      HOLD:    I2S_EN = 1'b0;
      default: ;
    endcase
  end

  assign I2S_DATA = drv_en ? drv_bit : 1'bz;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      // Strobe history resets high so a strobe still held at release is not a start.
      str_q      <= 1'b1;
      str_prev_q <= 1'b1;
      cmd_q      <= '0;
      idx_q      <= '0;
      rsh_q      <= '0;
      rdy_q      <= 1'b1;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
`ifdef LCD_3WIRE_READBACK_VERIFY_EN
      vfy_q      <= 1'b0;
`endif
    end else begin
      str_q      <= iSTR;
      str_prev_q <= str_q;
      unique case (state_q)
        IDLE: if (start) begin
          cmd_q <= iDATA;
          rdy_q <= 1'b0;
          ack_q <= 1'b0;
        end
        SETUP: if (tick) idx_q <= 4'd15;
        BIT_HI: if (tick) begin
          idx_q <= idx_q - 4'd1;
          if (cmd_q[9] && !idx_q[3]) rsh_q <= {rsh_q[6:0], I2S_DATA};
        end
        // idx_q doubles as the two-tick GAP counter.
        HOLD: if (tick) idx_q <= 4'd1;
        GAP: if (tick) begin
          idx_q <= idx_q - 4'd1;
          if (idx_q == '0 && rdbk) begin
            cmd_q[9] <= 1'b1;
`ifdef LCD_3WIRE_READBACK_VERIFY_EN
            vfy_q    <= 1'b1;
`endif
          end
        end
        DONE: begin
          rdy_q <= 1'b1;
`ifdef LCD_3WIRE_READBACK_VERIFY_EN
          ack_q <= vfy_q ? (rsh_q == cmd_q[7:0]) : 1'b1;
          vfy_q <= 1'b0;
`else
          ack_q <= 1'b1;
`endif
          if (cmd_q[9]) rdata_q <= rsh_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_3wire_serial_ctrl.sv
`timescale 1ns/1ps
module tb_lcd_3wire_serial_ctrl;
  localparam int unsigned CD  = 4;
  localparam int          LIM = 120 * CD;
`ifdef LCD_3WIRE_READBACK_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iSTR = 1'b0;
  logic [15:0] iDATA = '0;
  logic        oACK, oRDY, oCLK;
  logic [7:0]  oRDATA;
  logic        I2S_EN, I2S_CLK;
  wire         I2S_DATA;

  logic        pdrv = 1'b0;
  logic        pval = 1'b0;
  logic [7:0]  panel_resp = '0;
  bit          panel_en = 1'b1;

  pullup (I2S_DATA);
  assign I2S_DATA = pdrv ? pval : 1'bz;

  lcd_3wire_serial_ctrl #(.CLK_DIV(CD)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iSTR(iSTR),
    .oACK(oACK), .oRDY(oRDY), .oCLK(oCLK), .oRDATA(oRDATA),
    .I2S_EN(I2S_EN), .I2S_CLK(I2S_CLK), .I2S_DATA(I2S_DATA)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // ---------------- panel model / frame monitor ----------------
  typedef struct { logic [15:0] bits; int rises; int en_low; } frame_t;
  frame_t      fr_q[$];
  int          gap_q[$];
  logic [15:0] exp_fr[$];
  logic [15:0] cap = '0;
  int          rises = 16, en_low = 0, en_high = 1000;
  logic        prev_en = 1'b1, prev_sclk = 1'b1;

  always @(negedge iCLK) begin
    if (!I2S_EN) begin
      if (prev_en) begin
        rises = 0; cap = '0; en_low = 0;
        gap_q.push_back(en_high);
      end
      en_low++;
      if (I2S_CLK && !prev_sclk) begin
        if (rises < 16) cap[4'(15 - rises)] = I2S_DATA;
        rises++;
      end
      if (!I2S_CLK && panel_en && cap[9] && rises >= 8 && rises < 16) begin
        pdrv = 1'b1;
        pval = panel_resp[3'(15 - rises)];
      end
    end else begin
      pdrv = 1'b0;
      if (!prev_en) begin
        fr_q.push_back('{bits: cap, rises: rises, en_low: en_low});
        en_high = 0;
      end
      en_high++;
    end
    prev_en   = I2S_EN;
    prev_sclk = I2S_CLK;
  end

  // ---------------- reference model ----------------
  function automatic void add_exp(input logic [15:0] w, input logic [7:0] r);
    if (w[9]) exp_fr.push_back({w[15:8], r});
    else begin
      exp_fr.push_back(w);
      if (VFY) exp_fr.push_back({w[15:10], 1'b1, w[8], r});
    end
  endfunction

  function automatic void model_result(input logic [15:0] w, input logic [7:0] r,
                                       inout logic [7:0] rd, output logic ack);
    ack = 1'b1;
    if (w[9]) rd = r;
    else if (VFY) begin
      rd  = r;
      ack = (r == w[7:0]);
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic start_xfer(input logic [15:0] w, input string name);
    @(negedge iCLK);
    iDATA = w;
    iSTR  = 1'b1;
    repeat (2) @(negedge iCLK);
    chk({name, " rdy_low"}, 32'(oRDY), 32'd0);
  endtask

  task automatic wait_rdy(input string name, output int n);
    n = 2;
    while (!oRDY && n < LIM) begin
      @(negedge iCLK);
      n++;
    end
    checks++;
    if (!oRDY) begin
      failures++;
      $display("FAIL %s timeout: oRDY still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic check_frames(input string name);
    chk({name, " frames"}, 32'(fr_q.size()), 32'(exp_fr.size()));
    for (int i = 0; i < fr_q.size() && i < exp_fr.size(); i++) begin
      chk($sformatf("%s f%0d bits", name, i), 32'(fr_q[i].bits), 32'(exp_fr[i]));
      chk($sformatf("%s f%0d rises", name, i), 32'(fr_q[i].rises), 32'd16);
      chk($sformatf("%s f%0d en_low", name, i), 32'(fr_q[i].en_low), 32'(34 * CD));
    end
  endtask

  task automatic do_xfer(input logic [15:0] w, input logic [7:0] r, input logic [7:0] erd,
                         input logic eack, input string name);
    int n, nf;
    panel_resp = r;
    fr_q.delete();
    exp_fr.delete();
    add_exp(w, r);
    nf = exp_fr.size();
    start_xfer(w, name);
    wait_rdy(name, n);
    chk_rng({name, " latency"}, n, 36 * CD * nf + 4, 36 * CD * nf + CD + 3);
    iSTR = 1'b0;
    chk({name, " rdata"}, 32'(oRDATA), 32'(erd));
    chk({name, " ack"}, 32'(oACK), 32'(eack));
    check_frames(name);
    chk({name, " idle_data"}, 32'(I2S_DATA), 32'd1);
  endtask

  typedef struct {
    logic [15:0] w; logic [7:0] r;
    logic [7:0] rd_n; logic ack_n;
    logic [7:0] rd_v; logic ack_v;
    string name;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [15:0] w;
    logic [7:0]  r, model_rd;
    logic        eack, prev;
    int          n, lowcnt, encnt;
    int          tq[$];

    tbl[0] = '{16'h0801, 8'h01, 8'h00, 1'b1, 8'h01, 1'b1, "wr_0801"};
    tbl[1] = '{16'h0E00, 8'hA5, 8'hA5, 1'b1, 8'hA5, 1'b1, "rd_a5"};
    tbl[2] = '{16'h7C3F, 8'h3E, 8'hA5, 1'b1, 8'h3E, 1'b0, "wr_3f_bad"};
    tbl[3] = '{16'h7C3F, 8'h3F, 8'hA5, 1'b1, 8'h3F, 1'b1, "wr_3f_ok"};
    tbl[4] = '{16'hFE5A, 8'h3C, 8'h3C, 1'b1, 8'h3C, 1'b1, "rd_3c"};
    tbl[5] = '{16'h0000, 8'hFF, 8'h3C, 1'b1, 8'hFF, 1'b0, "wr_00"};

    // reset values
    #2 iRST = 1'b1;
    #1;
    chk("rst rdy", 32'(oRDY), 32'd1);
    chk("rst ack", 32'(oACK), 32'd0);
    chk("rst rdata", 32'(oRDATA), 32'd0);
    chk("rst oclk", 32'(oCLK), 32'd0);
    chk("rst en", 32'(I2S_EN), 32'd1);
    chk("rst sclk", 32'(I2S_CLK), 32'd1);
    chk("rst data", 32'(I2S_DATA), 32'd1);
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);

    // directed table
    for (int i = 0; i < 6; i++)
      do_xfer(tbl[i].w, tbl[i].r, VFY ? tbl[i].rd_v : tbl[i].rd_n,
              VFY ? tbl[i].ack_v : tbl[i].ack_n, tbl[i].name);

    // read with no panel response: line must be released (pulled high)
    panel_en = 1'b0;
    do_xfer(16'h0E00, 8'hFF, 8'hFF, 1'b1, "rd_hiz");
    panel_en = 1'b1;
    model_rd = 8'hFF;

    // randomized transfers against the model
    for (int i = 0; i < 12; i++) begin
      w    = 16'($urandom);
      w[8] = 1'b0;
      r    = 8'($urandom);
      repeat ($urandom_range(0, 7)) @(negedge iCLK);
      model_result(w, r, model_rd, eack);
      do_xfer(w, r, model_rd, eack, $sformatf("rnd%0d", i));
    end

    // held strobe: no second frame until iSTR falls and rises again
    panel_resp = 8'h5A;
    fr_q.delete();
    exp_fr.delete();
    add_exp(16'h1034, 8'h5A);
    start_xfer(16'h1034, "held1");
    wait_rdy("held1", n);
    lowcnt = 0;
    encnt  = 0;
    for (int c = 0; c < 40 * int'(CD); c++) begin
      @(negedge iCLK);
      if (!oRDY) lowcnt++;
      if (!I2S_EN) encnt++;
    end
    chk("held rdy_low_cycles", 32'(lowcnt), 32'd0);
    chk("held en_low_cycles", 32'(encnt), 32'd0);
    check_frames("held1");
    iSTR = 1'b0;
    repeat (2 * CD) @(negedge iCLK);
    fr_q.delete();
    exp_fr.delete();
    add_exp(16'h2055, 8'h5A);
    start_xfer(16'h2055, "held2");
    wait_rdy("held2", n);
    iSTR = 1'b0;
    check_frames("held2");

    // sequencer loop clocked by oCLK
    fr_q.delete();
    gap_q.delete();
    exp_fr.delete();
    panel_resp = 8'hC3;
    for (int k = 0; k < 9; k++) begin
      w = 16'($urandom) & 16'hFCFF;
      add_exp(w, 8'hC3);
      n = 0;
      do begin
        @(posedge oCLK);
        #1;
        n++;
      end while (!oRDY && n < 100);
      chk($sformatf("seq%0d ready", k), 32'(oRDY), 32'd1);
      iDATA = w;
      iSTR  = 1'b1;
      @(posedge oCLK);
      #1;
      chk($sformatf("seq%0d rdy_low", k), 32'(oRDY), 32'd0);
      iSTR = 1'b0;
    end
    @(negedge iCLK);
    wait_rdy("seq_end", n);
    check_frames("seq");
    for (int i = 1; i < gap_q.size(); i++)
      chk_rng($sformatf("seq gap%0d", i), gap_q[i], 2 * CD, 1000000);

    // reset mid-frame at bit 10
    fr_q.delete();
    panel_resp = 8'h00;
    @(negedge iCLK);
    iDATA = 16'h0801;
    iSTR  = 1'b1;
    n = 0;
    do begin
      @(negedge iCLK);
      #1;
      n++;
    end while (rises != 6 && n < LIM);
    chk("midrst reach_bit10", 32'(rises), 32'd6);
    iRST = 1'b1;
    #1;
    chk("midrst en", 32'(I2S_EN), 32'd1);
    chk("midrst sclk", 32'(I2S_CLK), 32'd1);
    chk("midrst data", 32'(I2S_DATA), 32'd1);
    chk("midrst rdy", 32'(oRDY), 32'd1);
    chk("midrst ack", 32'(oACK), 32'd0);
    chk("midrst oclk", 32'(oCLK), 32'd0);
    iSTR = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    prev  = oCLK;
    encnt = 0;
    tq.delete();
    for (int c = 1; c <= 4 * int'(CD) + 1; c++) begin
      @(negedge iCLK);
      if (oCLK != prev) tq.push_back(c);
      prev = oCLK;
      if (!I2S_EN) encnt++;
    end
    chk("oclk toggles", 32'(tq.size()), 32'd4);
    if (tq.size() > 0) chk("oclk first", 32'(tq[0]), 32'(CD));
    for (int i = 1; i < tq.size(); i++)
      chk($sformatf("oclk half%0d", i), 32'(tq[i] - tq[i-1]), 32'(CD));
    for (int c = 0; c < 40 * int'(CD); c++) begin
      @(negedge iCLK);
      if (!I2S_EN) encnt++;
    end
    chk("midrst no_resume", 32'(encnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
